// File: rtl/minefield_controller_if.sv
// Command and board-state bundle between the player input logic and minefield_controller.
interface minefield_controller_if;
    logic        mine_load;
    logic [63:0] mine_in;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        btn_flag;
    logic        btn_step;
    logic [63:0] mineMap;
    logic [63:0] flagMap;
    logic [63:0] stepMap;
    logic [5:0]  cursor;
    logic [3:0]  adj_count;
    logic        adj_valid;
    logic        busy;
    logic        game_over;
    logic        game_won;

    modport master (
        output mine_load, mine_in, btn_up, btn_down, btn_left, btn_right, btn_flag, btn_step,
        input  mineMap, flagMap, stepMap, cursor, adj_count, adj_valid, busy, game_over, game_won
    );

    modport slave (
        input  mine_load, mine_in, btn_up, btn_down, btn_left, btn_right, btn_flag, btn_step,
        output mineMap, flagMap, stepMap, cursor, adj_count, adj_valid, busy, game_over, game_won
    );
endinterface

// File: rtl/minefield_controller.sv
// 8x8 minesweeper game-state owner: cursor, mine/flag/step maps, serial neighbour scan.
// Define MINEFIELD_WRAP_EN for cursor wrap-around; default build saturates at the board edge.
module minefield_controller #(
    parameter logic [5:0] CURSOR_RESET = 6'd0
) (
    input  logic                  clk,
    input  logic                  resetn,
    minefield_controller_if.slave bus
);

`ifdef MINEFIELD_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SCAN, END} state_t;

    state_t      state, state_n;
    logic [63:0] mine_map, mine_n;
    logic [63:0] flag_map, flag_n;
    logic [63:0] step_map, step_n;
    logic [5:0]  cursor, cursor_n;
    logic [5:0]  origin, origin_n;
    logic [2:0]  idx, idx_n;
    logic [3:0]  acc, acc_n;
    logic [3:0]  acc_sum;
    logic [3:0]  adj_count, adj_count_n;
    logic        adj_valid, adj_valid_n;
    logic        over, over_n;
    logic        won, won_n;

    logic [2:0]  row, col;
    logic [3:0]  dr, dc, nr, nc;
    logic        nb_mine;

    assign row = cursor[5:3];
    assign col = cursor[2:0];

    // Offsets are 4-bit two's complement; bit 3 of the sum flags both -1 and 8 as off-board.
    always_comb begin
        dr = '0;
        dc = '0;
        case (idx)
            3'd0: dr = 4'hF;
            3'd1: begin dr = 4'hF; dc = 4'h1; end
            3'd2: dc = 4'h1;
            3'd3: begin dr = 4'h1; dc = 4'h1; end
            3'd4: dr = 4'h1;
            3'd5: begin dr = 4'h1; dc = 4'hF; end
            3'd6: dc = 4'hF;
            default: begin dr = 4'hF; dc = 4'hF; end
        endcase
        nr      = {1'b0, origin[5:3]} + dr;
        nc      = {1'b0, origin[2:0]} + dc;
        nb_mine = ~nr[3] & ~nc[3] & mine_map[{nr[2:0], nc[2:0]}];
    end

    assign acc_sum = acc + {3'b000, nb_mine};

    always_comb begin
        state_n     = state;
        mine_n      = mine_map;
        flag_n      = flag_map;
        step_n      = step_map;
        cursor_n    = cursor;
        origin_n    = origin;
        idx_n       = idx;
        acc_n       = acc;
        adj_count_n = adj_count;
        adj_valid_n = 1'b0;
        over_n      = over;
        won_n       = won;

        if (bus.mine_load) begin
            mine_n   = bus.mine_in;
            flag_n   = '0;
            step_n   = '0;
            cursor_n = CURSOR_RESET;
            over_n   = 1'b0;
            won_n    = 1'b0;
            state_n  = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // Only the highest-priority button is considered; if it is ignored, nothing happens.
                    if (bus.btn_step) begin
                        if (!flag_map[cursor] && !step_map[cursor]) begin
                            step_n[cursor] = 1'b1;
                            if (mine_map[cursor]) begin
                                over_n  = 1'b1;
                                state_n = END;
                            end else begin
                                origin_n = cursor;
                                idx_n    = '0;
                                acc_n    = '0;
                                state_n  = SCAN;
                            end
                        end
                    end else if (bus.btn_flag) begin
                        if (!step_map[cursor])
                            flag_n[cursor] = ~flag_map[cursor];
                    end else if (bus.btn_up) begin
                        if (row != 3'd0 || WRAP) cursor_n = {row - 3'd1, col};
                    end else if (bus.btn_down) begin
                        if (row != 3'd7 || WRAP) cursor_n = {row + 3'd1, col};
                    end else if (bus.btn_left) begin
                        if (col != 3'd0 || WRAP) cursor_n = {row, col - 3'd1};
                    end else if (bus.btn_right) begin
                        if (col != 3'd7 || WRAP) cursor_n = {row, col + 3'd1};
                    end
                end
                SCAN: begin
                    if (idx == 3'd7) begin
                        adj_count_n = acc_sum;
                        adj_valid_n = 1'b1;
                        if (&(step_map | mine_map)) begin
                            won_n   = 1'b1;
                            state_n = END;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        acc_n = acc_sum;
                        idx_n = idx + 3'd1;
                    end
                end
                END: ;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            mine_map  <= '0;
            flag_map  <= '0;
            step_map  <= '0;
            cursor    <= CURSOR_RESET;
            origin    <= '0;
            idx       <= '0;
            acc       <= '0;
            adj_count <= '0;
            adj_valid <= 1'b0;
            over      <= 1'b0;
            won       <= 1'b0;
        end else begin
            state     <= state_n;
            mine_map  <= mine_n;
            flag_map  <= flag_n;
            step_map  <= step_n;
            cursor    <= cursor_n;
            origin    <= origin_n;
            idx       <= idx_n;
            acc       <= acc_n;
            adj_count <= adj_count_n;
            adj_valid <= adj_valid_n;
            over      <= over_n;
            won       <= won_n;
        end
    end

    assign bus.mineMap   = mine_map;
    assign bus.flagMap   = flag_map;
    assign bus.stepMap   = step_map;
    assign bus.cursor    = cursor;
    assign bus.adj_count = adj_count;
    assign bus.adj_valid = adj_valid;
    assign bus.busy      = (state == SCAN);
    assign bus.game_over = over;
    assign bus.game_won  = won;

endmodule

// File: tb/tb_minefield_controller.sv
// Self-checking bench for minefield_controller: directed scenarios plus random play
// compared every cycle against a tile-array game model.
module tb_minefield_controller;

`ifdef MINEFIELD_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam logic [5:0] B_STEP  = 6'b100000;
    localparam logic [5:0] B_FLAG  = 6'b010000;
    localparam logic [5:0] B_UP    = 6'b001000;
    localparam logic [5:0] B_DOWN  = 6'b000100;
    localparam logic [5:0] B_LEFT  = 6'b000010;
    localparam logic [5:0] B_RIGHT = 6'b000001;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    minefield_controller_if mif ();

    minefield_controller #(.CURSOR_RESET(6'd0)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (mif)
    );

    always #5 clk = ~clk;

    // Game model: plain tile arrays and row/column integers.
    bit m_mine [64];
    bit m_flag [64];
    bit m_step [64];
    int m_row, m_col;
    int m_scan_left, m_pending, m_adj;
    bit m_valid, m_over, m_won;

    function automatic logic [63:0] pack(input bit a [64]);
        logic [63:0] v;
        for (int i = 0; i < 64; i++) v[i] = a[i];
        return v;
    endfunction

    function automatic int count_adjacent(input int r, input int c);
        int n = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
                    n += int'(m_mine[(r + dr) * 8 + c + dc]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_mine[i] = 0; m_flag[i] = 0; m_step[i] = 0;
        end
        m_row = 0; m_col = 0;
        m_scan_left = 0; m_pending = 0; m_adj = 0;
        m_valid = 0; m_over = 0; m_won = 0;
    endtask

    task automatic model_apply(input logic ld, input logic [63:0] mi, input logic [5:0] b);
        int t;
        bit all_clear;
        m_valid = 0;
        t = m_row * 8 + m_col;
        if (ld) begin
            for (int i = 0; i < 64; i++) begin
                m_mine[i] = mi[i]; m_flag[i] = 0; m_step[i] = 0;
            end
            m_row = 0; m_col = 0;
            m_over = 0; m_won = 0; m_scan_left = 0;
        end else if (m_scan_left > 0) begin
            m_scan_left--;
            if (m_scan_left == 0) begin
                m_adj = m_pending;
                m_valid = 1;
                all_clear = 1;
                for (int i = 0; i < 64; i++)
                    if (!m_step[i] && !m_mine[i]) all_clear = 0;
                if (all_clear) m_won = 1;
            end
        end else if (!m_over && !m_won) begin
            if (b[5]) begin
                if (!m_flag[t] && !m_step[t]) begin
                    m_step[t] = 1;
                    if (m_mine[t]) m_over = 1;
                    else begin
                        m_pending = count_adjacent(m_row, m_col);
                        m_scan_left = 8;
                    end
                end
            end else if (b[4]) begin
                if (!m_step[t]) m_flag[t] = !m_flag[t];
            end else if (b[3]) begin
                if (m_row > 0) m_row--; else if (WRAP) m_row = 7;
            end else if (b[2]) begin
                if (m_row < 7) m_row++; else if (WRAP) m_row = 0;
            end else if (b[1]) begin
                if (m_col > 0) m_col--; else if (WRAP) m_col = 7;
            end else if (b[0]) begin
                if (m_col < 7) m_col++; else if (WRAP) m_col = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("mineMap",   mif.mineMap, pack(m_mine));
        check("flagMap",   mif.flagMap, pack(m_flag));
        check("stepMap",   mif.stepMap, pack(m_step));
        check("cursor",    64'(mif.cursor), 64'(m_row * 8 + m_col));
        check("adj_count", 64'(mif.adj_count), 64'(m_adj));
        check("adj_valid", 64'(mif.adj_valid), 64'(m_valid));
        check("busy",      64'(mif.busy), 64'(m_scan_left > 0));
        check("game_over", 64'(mif.game_over), 64'(m_over));
        check("game_won",  64'(mif.game_won), 64'(m_won));
    endtask

    task automatic cycle(input logic ld, input logic [63:0] mi, input logic [5:0] b);
        mif.mine_load = ld;
        mif.mine_in   = mi;
        {mif.btn_step, mif.btn_flag, mif.btn_up, mif.btn_down, mif.btn_left, mif.btn_right} = b;
        model_apply(ld, mi, b);
        @(posedge clk);
        #1;
        check_all();
        mif.mine_load = 1'b0;
        {mif.btn_step, mif.btn_flag, mif.btn_up, mif.btn_down, mif.btn_left, mif.btn_right} = '0;
    endtask

    task automatic press(input logic [5:0] b);
        cycle(1'b0, 64'h0, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) press(6'b0);
    endtask

    task automatic load(input logic [63:0] mi);
        cycle(1'b1, mi, 6'b0);
    endtask

    initial begin
        logic [63:0] mines;
        resetn = 1'b0;
        mif.mine_load = 1'b0;
        mif.mine_in   = '0;
        {mif.btn_step, mif.btn_flag, mif.btn_up, mif.btn_down, mif.btn_left, mif.btn_right} = '0;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #3 resetn = 1'b1;
        @(posedge clk);
        #1;

        // Safe step on tile 9 next to the single mine at tile 0.
        load(64'h1);
        press(B_DOWN);
        press(B_RIGHT);
        check("cursor9", 64'(mif.cursor), 64'd9);
        press(B_STEP);
        check("step9_map", mif.stepMap, 64'h200);
        check("step9_busy", 64'(mif.busy), 64'd1);
        idle(7);
        check("adj_not_yet", 64'(mif.adj_valid), 64'd0);
        idle(1);
        check("adj9_valid", 64'(mif.adj_valid), 64'd1);
        check("adj9_count", 64'(mif.adj_count), 64'd1);
        check("adj9_busy", 64'(mif.busy), 64'd0);
        idle(1);
        check("adj9_fall", 64'(mif.adj_valid), 64'd0);

        // Flag blocks stepping; unflagged mine step ends the game.
        press(B_UP);
        press(B_LEFT);
        press(B_FLAG);
        check("flag0", mif.flagMap, 64'h1);
        press(B_STEP);
        check("flagged_step", mif.stepMap, 64'h200);
        press(B_FLAG);
        check("unflag0", mif.flagMap, 64'h0);
        press(B_STEP);
        check("boom_over", 64'(mif.game_over), 64'd1);
        check("boom_valid", 64'(mif.adj_valid), 64'd0);
        check("boom_busy", 64'(mif.busy), 64'd0);
        press(B_RIGHT);
        check("end_frozen", 64'(mif.cursor), 64'd0);

        // Board-edge cursor behaviour.
        load(64'h0);
        press(B_LEFT);
        check("edge_left", 64'(mif.cursor), WRAP ? 64'd7 : 64'd0);
        load(64'h0);
        for (int i = 0; i < 7; i++) press(B_DOWN);
        for (int i = 0; i < 7; i++) press(B_RIGHT);
        check("cursor63", 64'(mif.cursor), 64'd63);
        press(B_DOWN);
        check("edge_down", 64'(mif.cursor), WRAP ? 64'd7 : 64'd63);

        // Last safe tile in the corner: count 3 and win on the same edge.
        load(~(64'h1 << 63));
        for (int i = 0; i < 7; i++) press(B_DOWN);
        for (int i = 0; i < 7; i++) press(B_RIGHT);
        press(B_STEP);
        idle(8);
        check("corner_count", 64'(mif.adj_count), 64'd3);
        check("corner_valid", 64'(mif.adj_valid), 64'd1);
        check("corner_won", 64'(mif.game_won), 64'd1);
        check("corner_over", 64'(mif.game_over), 64'd0);

        // Step beats right; moves ignored while scanning.
        load(64'h0);
        for (int i = 0; i < 5; i++) press(B_RIGHT);
        press(B_STEP | B_RIGHT);
        check("prio_cursor", 64'(mif.cursor), 64'd5);
        check("prio_step", mif.stepMap, 64'h20);
        press(B_RIGHT);
        check("busy_right", 64'(mif.cursor), 64'd5);
        idle(7);

        // Board load aborts a scan on its fourth cycle.
        load(64'h0);
        press(B_STEP);
        idle(3);
        load(64'h00F0_0000_0000_0F00);
        check("abort_busy", 64'(mif.busy), 64'd0);
        check("abort_mines", mif.mineMap, 64'h00F0_0000_0000_0F00);
        idle(8);

        // Asynchronous reset mid-scan.
        press(B_STEP);
        idle(2);
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 resetn = 1'b1;
        @(posedge clk);
        #1;

        // Random play.
        for (int n = 0; n < 2000; n++) begin
            if ((m_over || m_won) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 149) == 0)) begin
                mines = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                load(mines);
            end else begin
                press(6'($urandom & $urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
